// File: rtl/controller_fsm_if.sv
// Control/status bundle between the controller and the 16-bit datapath/memory.
interface controller_fsm_if;
  logic [15:0] instruction;
  logic [15:0] srcData;
  logic        C;
  logic        L;
  logic        F;
  logic        Z;
  logic        N;
  logic [15:0] pc;
  logic        addrSel;
  logic        memWrite;
  logic [3:0]  aluControl;
  logic [1:0]  exMemResultEn;
  logic [1:0]  mux4En;
  logic [1:0]  regpcCont;
  logic        pcRegEn;
  logic        srcRegEn;
  logic        dstRegEn;
  logic        immRegEn;
  logic        resultRegEn;
  logic        signEn;
  logic        regFileEn;
  logic        pcRegMuxEn;
  logic        shiftALUMuxEn;
  logic        irS;
  logic        regImmMuxEn;
  logic [4:0]  psr;

  modport master (
    input  instruction, srcData, C, L, F, Z, N,
    output pc, addrSel, memWrite, aluControl, exMemResultEn, mux4En, regpcCont,
           pcRegEn, srcRegEn, dstRegEn, immRegEn, resultRegEn, signEn, regFileEn,
           pcRegMuxEn, shiftALUMuxEn, irS, regImmMuxEn, psr
  );

  modport slave (
    output instruction, srcData, C, L, F, Z, N,
    input  pc, addrSel, memWrite, aluControl, exMemResultEn, mux4En, regpcCont,
           pcRegEn, srcRegEn, dstRegEn, immRegEn, resultRegEn, signEn, regFileEn,
           pcRegMuxEn, shiftALUMuxEn, irS, regImmMuxEn, psr
  );
endinterface

// File: rtl/controller_fsm.sv
// Multicycle control unit: owns PC/PSR, sequences fetch/decode/exec/mem/branch.
module controller_fsm #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic              clk,
  input logic              reset,
  controller_fsm_if.master bus
);
  localparam int unsigned W  = 16;
  localparam int unsigned FW = 5;

  localparam logic [3:0] OP_RTYPE  = 4'b0000;
  localparam logic [3:0] OP_MEM    = 4'b0100;
  localparam logic [3:0] OP_SHIFT  = 4'b1000;
  localparam logic [3:0] OP_BRANCH = 4'b1100;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JUMP  = 4'b1100;
  localparam logic [3:0] EXT_LSH   = 4'b0100;
  localparam logic [3:0] C_ADD = 4'b0101, C_SUB = 4'b1001, C_CMP = 4'b1011;
  localparam logic [3:0] C_AND = 4'b0001, C_OR  = 4'b0010, C_XOR = 4'b0011;
  localparam logic [3:0] C_MOV = 4'b1101;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_LDWB, S_BRANCH, S_JUMP
  } state_t;

  state_t          state, state_next;
  logic [W-1:0]    pc, pc_next, ireg, ireg_next;
  logic [FW-1:0]   psr, psr_next;

  logic            addr_sel, mem_write, src_en, sign_en, rf_en, shift_sel, reg_imm;
  logic [3:0]      alu_ctl;
  logic [1:0]      wb_sel, mux4_sel;

  // True for the ALU operation codes shared by R-type ext and immediate op
  function automatic logic is_alu(input logic [3:0] code);
    logic r;
    case (code)
      C_ADD, C_SUB, C_CMP, C_AND, C_OR, C_XOR, C_MOV: r = 1'b1;
      default:                                        r = 1'b0;
    endcase
    return r;
  endfunction

  // Operation code to datapath ALU control
  function automatic logic [3:0] alu_map(input logic [3:0] code);
    logic [3:0] r;
    case (code)
      C_SUB:   r = 4'b0001;
      C_CMP:   r = 4'b0010;
      C_AND:   r = 4'b0011;
      C_OR:    r = 4'b0100;
      C_XOR:   r = 4'b0101;
      C_MOV:   r = 4'b0110;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Next state chosen from the freshly fetched word; unknown encodings are NOPs
  function automatic state_t dispatch(input logic [W-1:0] w);
    state_t r;
    case (w[15:12])
      OP_RTYPE:  r = is_alu(w[7:4]) ? S_EXEC : S_FETCH;
      OP_SHIFT:  r = (w[7:4] == EXT_LSH || w[7:5] == 3'b000) ? S_EXEC : S_FETCH;
      OP_BRANCH: r = S_BRANCH;
      OP_MEM: begin
        case (w[7:4])
          EXT_LOAD, EXT_STOR: r = S_MEM;
          EXT_JUMP:           r = S_JUMP;
          default:            r = S_FETCH;
        endcase
      end
      default:   r = is_alu(w[15:12]) ? S_EXEC : S_FETCH;
    endcase
    return r;
  endfunction

  // Condition evaluation on latched flags {C,L,F,Z,N}
  function automatic logic cond_true(input logic [3:0] cond, input logic [FW-1:0] p);
    logic r;
    case (cond)
      4'b0000: r = p[1];
      4'b0001: r = ~p[1];
      4'b0010: r = p[4];
      4'b0011: r = ~p[4];
      4'b0110: r = p[0];
      4'b0111: r = ~p[0];
      4'b1000: r = p[2];
      4'b1001: r = ~p[2];
      4'b1100: r = ~p[0] & ~p[1];
      4'b1101: r = p[0] | p[1];
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [3:0]   op, ext, code;
  logic         imm_form, sets_flags, taken;
  logic [W-1:0] br_target;

  assign op         = ireg[15:12];
  assign ext        = ireg[7:4];
  assign imm_form   = (op != OP_RTYPE);
  assign code       = imm_form ? op : ext;
  assign sets_flags = (code == C_ADD) || (code == C_SUB) || (code == C_CMP);
  assign taken      = cond_true(ireg[11:8], psr);
  assign br_target  = pc + {{8{ireg[7]}}, ireg[7:0]} - W'(1);

  // State, PC, PSR and latched instruction registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      psr   <= '0;
      ireg  <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      psr   <= psr_next;
      ireg  <= ireg_next;
    end
  end

  // Next-state logic and Moore control decode
  always_comb begin
    state_next = state;
    pc_next    = pc;
    psr_next   = psr;
    ireg_next  = ireg;
    addr_sel   = 1'b0;
    mem_write  = 1'b0;
    src_en     = 1'b0;
    sign_en    = 1'b0;
    rf_en      = 1'b0;
    shift_sel  = 1'b0;
    reg_imm    = 1'b0;
    alu_ctl    = 4'b0000;
    wb_sel     = 2'b00;
    mux4_sel   = 2'b00;
    case (state)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        ireg_next  = bus.instruction;
        src_en     = 1'b1;
        pc_next    = pc + W'(1);
        state_next = dispatch(bus.instruction);
      end
      S_EXEC: begin
        state_next = S_FETCH;
        rf_en      = 1'b1;
        if (op == OP_SHIFT) begin
          shift_sel = 1'b1;
          if (ext != EXT_LSH) begin
            reg_imm = 1'b1;
            sign_en = 1'b1;
          end
        end else begin
          alu_ctl  = alu_map(code);
          mux4_sel = imm_form ? 2'b01 : 2'b00;
          sign_en  = imm_form && sets_flags;
          rf_en    = (code != C_CMP);
          if (code == C_MOV) wb_sel = 2'b10;
          if (sets_flags) psr_next = {bus.C, bus.L, bus.F, bus.Z, bus.N};
        end
      end
      S_MEM: begin
        addr_sel = 1'b1;
        if (ext == EXT_STOR) begin
          mem_write  = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_LDWB;
        end
      end
      S_LDWB: begin
        wb_sel     = 2'b01;
        rf_en      = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        if (taken) pc_next = br_target;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        if (taken) pc_next = bus.srcData;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  assign bus.pc            = pc;
  assign bus.psr           = psr;
  assign bus.addrSel       = addr_sel;
  assign bus.memWrite      = mem_write;
  assign bus.aluControl    = alu_ctl;
  assign bus.exMemResultEn = wb_sel;
  assign bus.mux4En        = mux4_sel;
  assign bus.regpcCont     = 2'b00;
  assign bus.srcRegEn      = src_en;
  assign bus.dstRegEn      = src_en;
  assign bus.immRegEn      = src_en;
  assign bus.signEn        = sign_en;
  assign bus.regFileEn     = rf_en;
  assign bus.shiftALUMuxEn = shift_sel;
  assign bus.regImmMuxEn   = reg_imm;
  // PC and IR live inside this controller, so the datapath copies stay idle
  assign bus.pcRegEn       = 1'b0;
  assign bus.pcRegMuxEn    = 1'b0;
  assign bus.irS           = 1'b0;
  assign bus.resultRegEn   = 1'b0;
endmodule

// File: tb/tb_controller_fsm.sv
// Scoreboard bench for controller_fsm: per-cycle expected control snapshots.
module tb_controller_fsm;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  controller_fsm_if dif ();

  controller_fsm #(.RESET_PC(16'h0000)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dif)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [4:0]  psr;
    logic        addr_sel;
    logic        mem_write;
    logic [3:0]  alu;
    logic [1:0]  wb;
    logic [1:0]  mux4;
    logic        rf_en;
    logic        sign_en;
    logic        shift_sel;
    logic        reg_imm;
    logic        dec_en;
  } snap_t;

  snap_t       expq[$];
  string       tagq[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        done = 1'b0;
  logic [15:0] epc;
  logic [4:0]  epsr;
  snap_t       nz;

  function automatic snap_t ctl(input logic a, input logic mw, input logic [3:0] alu,
                                input logic [1:0] wb, input logic [1:0] mux4, input logic rf,
                                input logic sg, input logic sh, input logic ri);
    snap_t s;
    s = '0;
    s.addr_sel = a;  s.mem_write = mw; s.alu = alu; s.wb = wb; s.mux4 = mux4;
    s.rf_en = rf;    s.sign_en = sg;   s.shift_sel = sh; s.reg_imm = ri;
    return s;
  endfunction

  function automatic snap_t observe();
    snap_t g;
    g.pc        = dif.pc;
    g.psr       = dif.psr;
    g.addr_sel  = dif.addrSel;
    g.mem_write = dif.memWrite;
    g.alu       = dif.aluControl;
    g.wb        = dif.exMemResultEn;
    g.mux4      = dif.mux4En;
    g.rf_en     = dif.regFileEn;
    g.sign_en   = dif.signEn;
    g.shift_sel = dif.shiftALUMuxEn;
    g.reg_imm   = dif.regImmMuxEn;
    g.dec_en    = dif.srcRegEn & dif.dstRegEn & dif.immRegEn;
    return g;
  endfunction

  // Push the expected snapshot for the cycle that starts at this rising edge
  task automatic cyc(input string tag, input snap_t e);
    @(posedge clk);
    #1;
    expq.push_back(e);
    tagq.push_back(tag);
  endtask

  // One instruction: DECODE, nmid middle cycles, then the next FETCH
  task automatic run(input string tag, input logic [15:0] word, input logic [4:0] flags,
                     input logic [15:0] src, input int nmid, input snap_t m1, input snap_t m2,
                     input logic [15:0] npc, input logic [4:0] npsr);
    snap_t e;
    dif.instruction = word;
    {dif.C, dif.L, dif.F, dif.Z, dif.N} = flags;
    dif.srcData = src;
    e = '0; e.pc = epc; e.psr = epsr; e.dec_en = 1'b1;
    cyc({tag, "/decode"}, e);
    if (nmid > 0) begin
      e = m1; e.pc = epc + 16'd1; e.psr = epsr;
      cyc({tag, "/stage1"}, e);
    end
    if (nmid > 1) begin
      e = m2; e.pc = epc + 16'd1; e.psr = epsr;
      cyc({tag, "/stage2"}, e);
    end
    e = '0; e.pc = npc; e.psr = npsr;
    cyc({tag, "/fetch"}, e);
    epc  = npc;
    epsr = npsr;
  endtask

  // Monitor: compare DUT outputs against the scoreboard each falling edge
  initial begin
    int    cycles;
    snap_t e;
    snap_t g;
    string t;
    cycles = 0;
    forever begin
      @(negedge clk);
      cycles++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        t = tagq.pop_front();
        g = observe();
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL %s: got %h, expected %h", t, g, e);
        end
      end
      if (done || cycles > 2000) begin
        if (!done) begin
          miscompares++;
          $display("FAIL watchdog: got %0d cycles without completion, expected fewer", cycles);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
    end
  end

  // Directed stimulus
  initial begin
    snap_t e;
    nz = '0;
    reset = 1'b1;
    dif.instruction = '0;
    dif.srcData = '0;
    {dif.C, dif.L, dif.F, dif.Z, dif.N} = 5'b00000;
    epc  = 16'h0000;
    epsr = 5'b00000;
    #1;
    e = '0;
    expq.push_back(e);
    tagq.push_back("reset");
    #11 reset = 1'b0;

    run("add",     16'h0152, 5'b10001, 16'h0000, 1, ctl(0,0,4'h0,2'b00,2'b00,1,0,0,0), nz, 16'h0001, 5'b10001);
    run("cmp",     16'h01B2, 5'b00010, 16'h0000, 1, ctl(0,0,4'h2,2'b00,2'b00,0,0,0,0), nz, 16'h0002, 5'b00010);
    run("jmp10",   16'h4EC5, 5'b00000, 16'h0010, 1, nz, nz, 16'h0010, 5'b00010);
    run("beq",     16'hC0FE, 5'b00000, 16'h0000, 1, nz, nz, 16'h000E, 5'b00010);
    run("bne",     16'hC105, 5'b00000, 16'h0000, 1, nz, nz, 16'h000F, 5'b00010);
    run("addi",    16'h5307, 5'b00000, 16'h0000, 1, ctl(0,0,4'h0,2'b00,2'b01,1,1,0,0), nz, 16'h0010, 5'b00000);
    run("andi",    16'h12FF, 5'b11111, 16'h0000, 1, ctl(0,0,4'h3,2'b00,2'b01,1,0,0,0), nz, 16'h0011, 5'b00000);
    run("mov",     16'h04D1, 5'b11111, 16'h0000, 1, ctl(0,0,4'h6,2'b10,2'b00,1,0,0,0), nz, 16'h0012, 5'b00000);
    run("movi",    16'hD4AA, 5'b11111, 16'h0000, 1, ctl(0,0,4'h6,2'b10,2'b01,1,0,0,0), nz, 16'h0013, 5'b00000);
    run("lsh",     16'h8143, 5'b11111, 16'h0000, 1, ctl(0,0,4'h0,2'b00,2'b00,1,0,1,0), nz, 16'h0014, 5'b00000);
    run("lshi",    16'h8215, 5'b11111, 16'h0000, 1, ctl(0,0,4'h0,2'b00,2'b00,1,1,1,1), nz, 16'h0015, 5'b00000);
    run("sub",     16'h0192, 5'b01100, 16'h0000, 1, ctl(0,0,4'h1,2'b00,2'b00,1,0,0,0), nz, 16'h0016, 5'b01100);
    run("load",    16'h4302, 5'b00000, 16'h0000, 2, ctl(1,0,4'h0,2'b00,2'b00,0,0,0,0),
                                                    ctl(0,0,4'h0,2'b01,2'b00,1,0,0,0), 16'h0017, 5'b01100);
    run("stor",    16'h4342, 5'b00000, 16'h0000, 1, ctl(1,1,4'h0,2'b00,2'b00,0,0,0,0), nz, 16'h0018, 5'b01100);
    run("illegal", 16'hF0F0, 5'b00000, 16'h0000, 0, nz, nz, 16'h0019, 5'b01100);
    run("juc",     16'h4EC5, 5'b00000, 16'h1234, 1, nz, nz, 16'h1234, 5'b01100);
    run("jtop",    16'h4EC5, 5'b00000, 16'hFFFF, 1, nz, nz, 16'hFFFF, 5'b01100);
    run("pc_wrap", 16'hF0F0, 5'b00000, 16'h0000, 0, nz, nz, 16'h0000, 5'b01100);
    run("buc_neg", 16'hCEFE, 5'b00000, 16'h0000, 1, nz, nz, 16'hFFFE, 5'b01100);
    run("jeq_nt",  16'h40C5, 5'b00000, 16'h5555, 1, nz, nz, 16'hFFFF, 5'b01100);
    run("blt",     16'hCC03, 5'b00000, 16'h0000, 1, nz, nz, 16'h0002, 5'b01100);

    // Reset lands in the middle of a store's MEM cycle
    dif.instruction = 16'h4342;
    {dif.C, dif.L, dif.F, dif.Z, dif.N} = 5'b00000;
    e = '0; e.pc = epc; e.psr = epsr; e.dec_en = 1'b1;
    cyc("rst_stor/decode", e);
    e = ctl(1,1,4'h0,2'b00,2'b00,0,0,0,0); e.pc = epc + 16'd1; e.psr = epsr;
    cyc("rst_stor/mem", e);
    #6 reset = 1'b1;
    #1;
    e = '0;
    expq.push_back(e);
    tagq.push_back("rst_stor/abort");
    #4 reset = 1'b0;
    epc  = 16'h0000;
    epsr = 5'b00000;

    run("add_after_rst", 16'h0152, 5'b00010, 16'h0000, 1, ctl(0,0,4'h0,2'b00,2'b00,1,0,0,0), nz, 16'h0001, 5'b00010);

    repeat (2) @(negedge clk);
    #1 done = 1'b1;
  end
endmodule
